// File: rtl/regs_wb_ctrl_if.sv
// Signal bundle between the writeback controller and the ALU path, load unit,
// decode stage and register file; clk/rst travel separately.
interface regs_wb_ctrl_if #(
    parameter int LDQ_DEPTH = 4
);
    localparam int CW = $clog2(LDQ_DEPTH) + 1;

    logic          alu_wb_valid;
    logic [4:0]    alu_wb_rd;
    logic [31:0]   alu_wb_data;
    logic          alu_wb_ready;

    logic          ld_issue_valid;
    logic [4:0]    ld_issue_rd;
    logic          ld_issue_ready;

    logic          ld_resp_valid;
    logic [31:0]   ld_resp_data;

    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          hazard_stall;

    logic          write_reg_enable;
    logic [4:0]    rd_addr;
    logic [31:0]   rd_write_data;

    logic [CW-1:0] ld_pending_cnt;
    logic          ld_resp_err;

    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_issue_valid, ld_issue_rd,
        output ld_resp_valid, ld_resp_data,
        output rs1_addr, rs2_addr,
        input  alu_wb_ready, ld_issue_ready, hazard_stall,
        input  write_reg_enable, rd_addr, rd_write_data,
        input  ld_pending_cnt, ld_resp_err
    );

    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_resp_valid, ld_resp_data,
        input  rs1_addr, rs2_addr,
        output alu_wb_ready, ld_issue_ready, hazard_stall,
        output write_reg_enable, rd_addr, rd_write_data,
        output ld_pending_cnt, ld_resp_err
    );
endinterface

// File: rtl/regs_wb_ctrl.sv
// Register-file writeback arbiter: in-order load destination queue, load-first
// write port arbitration, registered write port and scoreboard-style hazard detection.
module regs_wb_ctrl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    regs_wb_ctrl_if.slave  bus
);
    localparam int PW = $clog2(LDQ_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]           ldq [LDQ_DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;

    logic                 wr_en_q;
    logic [4:0]           rd_q;
    logic [31:0]          data_q;
    logic                 err_q;

    logic                 not_full;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 alu_take;
    logic                 take;
    logic [4:0]           sel_rd;
    logic [31:0]          sel_data;

    logic [PW-1:0]        offset [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0] occupied;
    logic [LDQ_DEPTH-1:0] match1;
    logic [LDQ_DEPTH-1:0] match2;
    logic                 hit1;
    logic                 hit2;

    always_comb begin
        not_full = (count < CW'(LDQ_DEPTH));
        push     = !rst && bus.ld_issue_valid && not_full;
        pop      = !rst && bus.ld_resp_valid && (count != '0);
        drop     = !rst && bus.ld_resp_valid && (count == '0);
        alu_take = !rst && !bus.ld_resp_valid && bus.alu_wb_valid;
        take     = pop || alu_take;
        sel_rd   = pop ? ldq[head] : bus.alu_wb_rd;
        sel_data = pop ? bus.ld_resp_data : bus.alu_wb_data;
    end

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            offset[i]   = PW'(i) - head;
            occupied[i] = ({1'b0, offset[i]} < count);
            match1[i]   = occupied[i] && (ldq[i] == bus.rs1_addr);
            match2[i]   = occupied[i] && (ldq[i] == bus.rs2_addr);
        end
        hit1 = (bus.rs1_addr != 5'd0) &&
               ((|match1) || (wr_en_q && (rd_q == bus.rs1_addr)));
        hit2 = (bus.rs2_addr != 5'd0) &&
               ((|match2) || (wr_en_q && (rd_q == bus.rs2_addr)));
    end

    always_comb begin
        bus.ld_issue_ready   = !rst && not_full;
        bus.alu_wb_ready     = !rst && !bus.ld_resp_valid;
        bus.hazard_stall     = !rst && (hit1 || hit2);
        bus.write_reg_enable = wr_en_q;
        bus.rd_addr          = rd_q;
        bus.rd_write_data    = data_q;
        bus.ld_pending_cnt   = count;
        bus.ld_resp_err      = err_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ldq[tail] <= bus.ld_issue_rd;
        end
    end

    // Destination 0 is consumed like any other write but never reaches the file.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                err_q <= 1'b1;
            end
            wr_en_q <= take && (sel_rd != 5'd0);
            if (take) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end
endmodule

// File: doc/regs_wb_ctrl.md
REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 4, meaning the number of outstanding load destination entries (power of two, at least 2).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port alu_wb_valid  in  1  ALU-path writeback request.
REQ-005 SHALL have ports alu_wb_rd  in  5 and alu_wb_data  in  32  ALU destination and result.
REQ-006 SHALL have port alu_wb_ready  out  1  ALU writeback accepted this cycle.
REQ-007 SHALL have ports ld_issue_valid  in  1 and ld_issue_rd  in  5  load issued to cache, with its destination.
REQ-008 SHALL have port ld_issue_ready  out  1  load queue can accept an issue.
REQ-009 SHALL have ports ld_resp_valid  in  1 and ld_resp_data  in  32  in-order cache load return (cannot be back-pressured).
REQ-010 SHALL have ports rs1_addr, rs2_addr  in  5 each  decode-stage source registers.
REQ-011 SHALL have port hazard_stall  out  1  a source register has a pending write.
REQ-012 SHALL have ports write_reg_enable  out  1, rd_addr  out  5, rd_write_data  out  32  register-file write port.
REQ-013 SHALL have port ld_pending_cnt  out  clog2(LDQ_DEPTH)+1  number of occupied queue entries.
REQ-014 SHALL have port ld_resp_err  out  1  sticky flag: a response arrived with the queue empty.

Function
REQ-015 SHALL keep a FIFO of LDQ_DEPTH destination indices, with head and tail pointers that wrap modulo LDQ_DEPTH and a separate occupancy count.
REQ-016 SHALL push ld_issue_rd when ld_issue_valid && ld_issue_ready; ld_issue_ready SHALL be 1 when count < LDQ_DEPTH, so a full queue blocks a same-cycle pop+push.
REQ-017 SHALL, on ld_resp_valid with count > 0, pop the head entry and pair it with ld_resp_data.
REQ-018 SHALL, on ld_resp_valid with count == 0, drop the response, set ld_resp_err, and still accept a same-cycle issue push.
REQ-019 SHALL arbitrate the write port with the load response first: alu_wb_ready = !ld_resp_valid.
REQ-020 SHALL register the selected write on the clock edge, so write_reg_enable, rd_addr and rd_write_data are valid one cycle after acceptance; if nothing is accepted, write_reg_enable SHALL be 0 and rd_addr/rd_write_data SHALL hold their values.
REQ-021 SHALL consume a write with destination 0 normally but drive write_reg_enable=0 for it.
REQ-022 SHALL drive hazard_stall=1 when, for rs1_addr or rs2_addr != 0, either (a) any occupied queue entry holds that index, or (b) write_reg_enable=1 and rd_addr equals it.
REQ-023 SHALL compute hazard_stall combinationally from current state; an entry popped this cycle still counts until the edge.
REQ-024 SHALL keep ld_pending_cnt equal to the occupancy count, changing by +1, -1 or 0 per cycle; a simultaneous push and pop SHALL leave it unchanged.
REQ-025 SHALL allow duplicate destinations in the queue, with a stall persisting until the last matching entry retires.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, empty the queue, zero both pointers and the count, and clear write_reg_enable, rd_addr, rd_write_data and ld_resp_err; any in-flight load is forgotten.
REQ-027 SHALL, while rst=1, drive ld_issue_ready=0, alu_wb_ready=0 and hazard_stall=0, and ignore all requests.

Verification
REQ-028 SHALL cover: alu_wb_valid, rd=5, data=0x1234 -> next cycle write_reg_enable=1, rd_addr=5, rd_write_data=0x1234.
REQ-029 SHALL cover: issue load rd=7; rs1_addr=7 -> hazard_stall=1; resp data=0xAA -> next cycle write to 7 with 0xAA, stall still 1; one cycle later stall=0.
REQ-030 SHALL cover: ld_resp_valid and alu_wb_valid in the same cycle -> alu_wb_ready=0, load written first, ALU write accepted the following cycle.
REQ-031 SHALL cover: 4 issues -> ld_issue_ready=0, ld_pending_cnt=4; 5 responses with the last one on an empty queue -> FIFO-order writes, then ld_resp_err=1 and the count stays 0.
REQ-032 SHALL cover: issue to rd=0 and ALU write to rd=0 -> write_reg_enable stays 0, rs1_addr=0 never stalls.
REQ-033 SHALL cover: rst asserted with 3 entries pending -> next cycle count=0, hazard_stall=0, write_reg_enable=0.
